// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the CPU fetch port
// and the CPU data port. One transaction at a time over a req/ack handshake;
// data always wins over fetch. Grants happen only in IDLE, and a RESP cycle
// after each completion keeps a still-asserted request from being re-granted.
// Optional feature: define ARB_TIMEOUT_EN to abort an access after TIMEOUT
// cycles without mem_ack (done pulses with rdata=0 together with arb_err).
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_done,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_done,
  output logic             cpu_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             arb_err
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_F, RESP} state_t;

  state_t           state_reg;
  logic             mem_req_reg;
  logic             mem_we_reg;
  logic [WIDTH-1:0] mem_addr_reg;
  logic [WIDTH-1:0] mem_wdata_reg;
  logic [WIDTH-1:0] if_rdata_reg;
  logic [WIDTH-1:0] d_rdata_reg;
  logic             if_done_reg;
  logic             d_done_reg;
  logic             arb_err_reg;

  logic             d_pending;

  assign d_pending = d_read | d_write;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_hit;

  // Counter value TIMEOUT-1 means this is the TIMEOUT-th cycle without an ack.
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
`endif

  // Arbitration FSM; every memory-side and response output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
      if_done_reg   <= 1'b0;
      d_done_reg    <= 1'b0;
      arb_err_reg   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_reg       <= '0;
`endif
    end else begin
      if_done_reg <= 1'b0;
      d_done_reg  <= 1'b0;
      arb_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
`ifdef ARB_TIMEOUT_EN
          cnt_reg <= '0;
`endif
          if (d_pending) begin
            // A simultaneous read and write is issued as a write.
            state_reg     <= BUSY_D;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= d_write;
            mem_addr_reg  <= d_addr;
            mem_wdata_reg <= d_wdata;
          end else if (if_req) begin
            state_reg     <= BUSY_F;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= if_addr;
            mem_wdata_reg <= '0;
          end
        end
        BUSY_D, BUSY_F: begin
          if (mem_ack) begin
            mem_req_reg <= 1'b0;
            state_reg   <= RESP;
            if (state_reg == BUSY_F) begin
              if_rdata_reg <= mem_rdata;
              if_done_reg  <= 1'b1;
            end else begin
              // A write completion keeps the last read data visible.
              if (!mem_we_reg) begin
                d_rdata_reg <= mem_rdata;
              end
              d_done_reg <= 1'b1;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            mem_req_reg <= 1'b0;
            state_reg   <= RESP;
            arb_err_reg <= 1'b1;
            if (state_reg == BUSY_F) begin
              if_rdata_reg <= '0;
              if_done_reg  <= 1'b1;
            end else begin
              d_rdata_reg <= '0;
              d_done_reg  <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end
        RESP: begin
          // The requester is still seeing its done pulse; never grant here.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign if_done   = if_done_reg;
  assign d_done    = d_done_reg;
  assign arb_err   = arb_err_reg;

  // Freeze the core while any of its requests is outstanding.
  assign cpu_stall = (if_req & ~if_done_reg) | (d_pending & ~d_done_reg);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Expected transactions are queued
// when a request is driven and popped when the matching done pulse appears.
module tb_mem_port_arbiter;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             if_req = 1'b0;
  logic [WIDTH-1:0] if_addr = '0;
  logic [WIDTH-1:0] if_rdata;
  logic             if_done;
  logic             d_read = 1'b0;
  logic             d_write = 1'b0;
  logic [WIDTH-1:0] d_addr = '0;
  logic [WIDTH-1:0] d_wdata = '0;
  logic [WIDTH-1:0] d_rdata;
  logic             d_done;
  logic             cpu_stall;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata = '0;
  logic             mem_ack = 1'b0;
  logic             arb_err;

  typedef struct {
    logic             is_d;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
  } exp_t;

  exp_t             sb_q[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [WIDTH-1:0] d_rdata_model = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .arb_err(arb_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Bounded wait for mem_req; an expired budget counts as a miscompare.
  task automatic wait_req(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_req_wait: mem_req=%b, required 1 within 20 cycles", tag, mem_req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, if_done, d_done, arb_err, cpu_stall} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: req/we/ifd/dd/err/stall=%b required 000000",
               {mem_req, mem_we, if_done, d_done, arb_err, cpu_stall});
    end
    vectors++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h d_rdata=%h required all 0",
               mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    exp_t e;
    bit   ok;
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h10;
    sb_q.push_back('{1'b0, 1'b0, 32'h10, 32'h0, 32'h00500093});
    #1;
    vectors++;
    if (cpu_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_stall_on: cpu_stall=%b required 1", cpu_stall);
    end
    wait_req("fetch", ok);
    e = sb_q[0];
    vectors++;
    if (mem_we !== e.we || mem_addr !== e.addr) begin
      miscompares++;
      $display("FAIL fetch_issue: we=%b addr=%h required we=%b addr=%h", mem_we, mem_addr, e.we, e.addr);
    end
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1 || if_done !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_hold: mem_req=%b if_done=%b required 1 0", mem_req, if_done);
    end
    mem_ack   = 1'b1;
    mem_rdata = e.rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    e = sb_q.pop_front();
    vectors++;
    if (if_done !== 1'b1 || d_done !== 1'b0 || if_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL fetch_done: if_done=%b d_done=%b if_rdata=%h required 1 0 %h",
               if_done, d_done, if_rdata, e.rdata);
    end
    vectors++;
    if (cpu_stall !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_release: cpu_stall=%b mem_req=%b required 0 0", cpu_stall, mem_req);
    end
    $display("txn fetch addr=%h rdata=%h", e.addr, if_rdata);
    if_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (if_done !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_pulse: if_done=%b mem_req=%b required 0 0", if_done, mem_req);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    bit   ok;
    @(negedge clk);
    d_write = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'hDEADBEEF;
    if_req  = 1'b1;
    if_addr = 32'h14;
    sb_q.push_back('{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, d_rdata_model});
    sb_q.push_back('{1'b0, 1'b0, 32'h14, 32'h0, 32'h00A00113});
    wait_req("prio_write", ok);
    e = sb_q[0];
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== e.addr || mem_wdata !== e.wdata) begin
      miscompares++;
      $display("FAIL prio_write_issue: we=%b addr=%h wdata=%h required 1 %h %h",
               mem_we, mem_addr, mem_wdata, e.addr, e.wdata);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0;
    e = sb_q.pop_front();
    d_write = 1'b0;
    vectors++;
    if (d_done !== 1'b1 || if_done !== 1'b0 || d_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL prio_write_done: d_done=%b if_done=%b d_rdata=%h required 1 0 %h",
               d_done, if_done, d_rdata, e.rdata);
    end
    $display("txn write addr=%h wdata=%h", e.addr, e.wdata);
    #1;
    vectors++;
    if (cpu_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_fetch_stall: cpu_stall=%b required 1", cpu_stall);
    end
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_resp_gap: mem_req=%b required 0 in grant cycle after d_done", mem_req);
    end
    @(negedge clk);
    e = sb_q[0];
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== e.addr) begin
      miscompares++;
      $display("FAIL prio_fetch_issue: req=%b we=%b addr=%h required 1 0 %h", mem_req, mem_we, mem_addr, e.addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = e.rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    e = sb_q.pop_front();
    vectors++;
    if (if_done !== 1'b1 || if_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL prio_fetch_done: if_done=%b if_rdata=%h required 1 %h", if_done, if_rdata, e.rdata);
    end
    $display("txn fetch addr=%h rdata=%h", e.addr, if_rdata);
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_slow_read();
    exp_t e;
    bit   ok;
    int   bad;
    @(negedge clk);
    d_read = 1'b1;
    d_addr = 32'h200;
    sb_q.push_back('{1'b1, 1'b0, 32'h200, 32'h0, 32'hCAFE0001});
    wait_req("slow", ok);
    e   = sb_q[0];
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req !== 1'b1 || mem_addr !== e.addr || mem_we !== 1'b0 || d_done !== 1'b0) bad++;
      if (i == 4) begin
        mem_ack   = 1'b1;
        mem_rdata = e.rdata;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL slow_stable: %0d unstable cycles, required 0", bad);
    end
    e = sb_q.pop_front();
    d_rdata_model = e.rdata;
    vectors++;
    if (d_done !== 1'b1 || mem_req !== 1'b0 || d_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL slow_done: d_done=%b mem_req=%b d_rdata=%h required 1 0 %h", d_done, mem_req, d_rdata, e.rdata);
    end
    $display("txn read addr=%h rdata=%h", e.addr, d_rdata);
    d_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (d_done !== 1'b0) begin
      miscompares++;
      $display("FAIL slow_pulse: d_done=%b required 0 one cycle later", d_done);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   ok;
    @(negedge clk);
    d_read = 1'b1;
    d_addr = 32'h400;
    sb_q.push_back('{1'b1, 1'b0, 32'h400, 32'h0, 32'h11112222});
    sb_q.push_back('{1'b1, 1'b0, 32'h404, 32'h0, 32'h33334444});
    wait_req("b2b", ok);
    mem_ack   = 1'b1;
    mem_rdata = sb_q[0].rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    e = sb_q.pop_front();
    vectors++;
    if (d_done !== 1'b1 || d_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL b2b_first: d_done=%b d_rdata=%h required 1 %h", d_done, d_rdata, e.rdata);
    end
    $display("txn read addr=%h rdata=%h", e.addr, d_rdata);
    d_addr = 32'h404;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_no_regrant: mem_req=%b required 0 after RESP", mem_req);
    end
    @(negedge clk);
    e = sb_q[0];
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== e.addr) begin
      miscompares++;
      $display("FAIL b2b_second_issue: req=%b addr=%h required 1 %h", mem_req, mem_addr, e.addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = e.rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    e = sb_q.pop_front();
    d_rdata_model = e.rdata;
    vectors++;
    if (d_done !== 1'b1 || d_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL b2b_second: d_done=%b d_rdata=%h required 1 %h", d_done, d_rdata, e.rdata);
    end
    $display("txn read addr=%h rdata=%h", e.addr, d_rdata);
    d_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_drop();
    exp_t e;
    bit   ok;
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h80;
    sb_q.push_back('{1'b0, 1'b0, 32'h80, 32'h0, 32'h00000013});
    wait_req("drop", ok);
    if_req    = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = sb_q[0].rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    e = sb_q.pop_front();
    vectors++;
    if (if_done !== 1'b1 || if_rdata !== e.rdata || cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_done: if_done=%b if_rdata=%h stall=%b required 1 %h 0",
               if_done, if_rdata, cpu_stall, e.rdata);
    end
    $display("txn fetch(dropped) addr=%h rdata=%h", e.addr, if_rdata);
    repeat (2) @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0 || if_done !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_idle: mem_req=%b if_done=%b required 0 0", mem_req, if_done);
    end
  endtask

  task automatic test_reset_busy();
    exp_t e;
    bit   ok;
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h40;
    wait_req("rstbusy", ok);
    #2;
    rst_n  = 1'b0;
    if_req = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_we, if_done, d_done, arb_err, cpu_stall} !== 6'b0 ||
        {mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      miscompares++;
      $display("FAIL rstbusy_clear: ctrl=%b addr=%h if_rdata=%h d_rdata=%h required all 0",
               {mem_req, mem_we, if_done, d_done, arb_err, cpu_stall}, mem_addr, if_rdata, d_rdata);
    end
    d_rdata_model = '0;
    $display("txn fetch addr=%h abandoned by reset", if_addr);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (if_done !== 1'b0 || mem_req !== 1'b0 || if_rdata !== '0) begin
      miscompares++;
      $display("FAIL rstbusy_late_ack: if_done=%b mem_req=%b if_rdata=%h required 0 0 0",
               if_done, mem_req, if_rdata);
    end
    if_req  = 1'b1;
    if_addr = 32'h44;
    sb_q.push_back('{1'b0, 1'b0, 32'h44, 32'h0, 32'h00100073});
    wait_req("rstbusy_fresh", ok);
    e = sb_q[0];
    vectors++;
    if (mem_addr !== e.addr || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL rstbusy_fresh_issue: addr=%h we=%b required %h 0", mem_addr, mem_we, e.addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = e.rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    e = sb_q.pop_front();
    vectors++;
    if (if_done !== 1'b1 || if_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL rstbusy_fresh_done: if_done=%b if_rdata=%h required 1 %h", if_done, if_rdata, e.rdata);
    end
    $display("txn fetch addr=%h rdata=%h", e.addr, if_rdata);
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    exp_t e;
    bit   ok;
    int   n;
    int   bad;
    @(negedge clk);
    d_read = 1'b1;
    d_addr = 32'h300;
`ifdef ARB_TIMEOUT_EN
    sb_q.push_back('{1'b1, 1'b0, 32'h300, 32'h0, 32'h0});
`else
    sb_q.push_back('{1'b1, 1'b0, 32'h300, 32'h0, 32'h0BADF00D});
`endif
    wait_req("timeout", ok);
    n   = 0;
    bad = 0;
`ifdef ARB_TIMEOUT_EN
    while (mem_req === 1'b1 && n < 40) begin
      if (arb_err !== 1'b0 || d_done !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != TIMEOUT || bad != 0) begin
      miscompares++;
      $display("FAIL timeout_len: mem_req high %0d cycles (%0d early flags), required %0d (0)", n, bad, TIMEOUT);
    end
    e = sb_q.pop_front();
    d_rdata_model = e.rdata;
    vectors++;
    if (arb_err !== 1'b1 || d_done !== 1'b1 || d_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL timeout_err: arb_err=%b d_done=%b d_rdata=%h required 1 1 %h", arb_err, d_done, d_rdata, e.rdata);
    end
    $display("txn read addr=%h timed out rdata=%h", e.addr, d_rdata);
    d_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (arb_err !== 1'b0 || d_done !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse: arb_err=%b d_done=%b required 0 0", arb_err, d_done);
    end
`else
    for (int i = 0; i < TIMEOUT + 8; i++) begin
      if (mem_req !== 1'b1 || arb_err !== 1'b0 || d_done !== 1'b0) bad++;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL notimeout_wait: %0d of %0d cycles lost mem_req or flagged, required 0", bad, n);
    end
    e = sb_q[0];
    mem_ack   = 1'b1;
    mem_rdata = e.rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    e = sb_q.pop_front();
    d_rdata_model = e.rdata;
    vectors++;
    if (d_done !== 1'b1 || arb_err !== 1'b0 || d_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL notimeout_done: d_done=%b arb_err=%b d_rdata=%h required 1 0 %h", d_done, arb_err, d_rdata, e.rdata);
    end
    $display("txn read addr=%h rdata=%h after long wait", e.addr, d_rdata);
    d_read = 1'b0;
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_slow_read();
    test_back_to_back();
    test_drop();
    test_reset_busy();
    test_timeout();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
